ffpack_stim_gen: RTL and testbench
==================================

Name: ffpack_stim_gen

Overview:
- Upstream stimulus source for the FF-packing test top: drives its serial data inputs (ina, inb), clock enable (cen) and synchronous clear (rst) from a deterministic LFSR.
- Issues periodic clear pulses, so on hardware all packed-FF variants (posedge/negedge, CE, SR/SS, async) are exercised without external pins.
- Runs a fixed-length sequence on request and reports completion.

Parameters:
- LFSR_WIDTH, 16, LFSR width. Fixed at 16; the feedback mask is defined only for 16.
- SEED, 16'hACE1, LFSR load value at start. A value of 0 is replaced by 16'h0001.
- CEN_PERIOD, 3, cen_o asserts 1 run cycle out of every CEN_PERIOD. Legal range 1..255; a value of 1 holds cen_o high for the whole run.
- RST_INTERVAL, 64, run cycles between clear pulses. Must be 2 or more.
- RUN_LENGTH, 1024, run cycles per sequence. Legal range 1..65535.

Ports:
- clk, input, 1, single clock; every register updates on posedge.
- rst, input, 1, synchronous active-high reset of this block.
- start, input, 1, level-sampled request to begin a sequence.
- busy, output, 1, high in RUN and PULSE.
- done, output, 1, high in DONE.
- cen_o, output, 1, clock enable to downstream.
- rst_o, output, 1, synchronous clear to downstream.
- ina_o, output, 1, serial data A, equal to lfsr[0].
- inb_o, output, 1, serial data B, equal to lfsr[1].
- cycle_cnt, output, 16, number of run cycles completed.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- While rst is high at a posedge:
  - state goes to IDLE; lfsr, cycle_cnt and cen_cnt clear to 0.
  - all outputs are 0 on the next cycle.
  - A reset mid-run aborts the run immediately, with no final pulse.
- FSM states: IDLE, RUN, PULSE, DONE.
- IDLE:
  - Outputs are 0.
  - start=1 loads lfsr=SEED (or 1 if SEED=0), cycle_cnt=0, cen_cnt=0, then goes to RUN.
- RUN (one posedge = one run cycle):
  - lfsr steps as a Galois right shift: next = (lfsr>>1) XOR (lfsr[0] ? 16'hB400 : 0).
  - cycle_cnt increments by 1.
  - cen_cnt counts modulo CEN_PERIOD.
  - cen_o = (cen_cnt==0). It is registered, so its value holds during the cycle the state is visible.
  - ina_o and inb_o are the current lfsr bits, so the first run cycle presents SEED bits.
- Transitions out of RUN, evaluated on the incremented count:
  - cycle_cnt == RUN_LENGTH: go to DONE. This takes priority over the clear pulse.
  - Otherwise, cycle_cnt mod RST_INTERVAL == 0: go to PULSE.
  - Otherwise, stay in RUN.
- PULSE (exactly 1 cycle):
  - rst_o=1 and cen_o=1, so the downstream CE-gated clear takes effect.
  - lfsr, cycle_cnt and cen_cnt hold.
  - ina_o and inb_o hold their last values.
  - Returns to RUN.
- DONE:
  - done=1; cen_o, rst_o, ina_o and inb_o are 0; cycle_cnt holds at RUN_LENGTH.
  - start=1 reloads exactly as from IDLE and goes to RUN. done drops the same cycle busy rises.
- start is ignored in RUN and PULSE.
- rst_o is high only in PULSE; no other state asserts it.
- busy=1 in RUN and PULSE. busy and done are never both high.
- cycle_cnt is 16 bits and never wraps, because RUN_LENGTH is at most 65535.

Optional Feature:
- Macro: FFPACK_STIM_HOLD_EN.
- With the macro defined, an extra input port hold (1 bit) is added.
  - hold=1 in RUN freezes lfsr, cycle_cnt, cen_cnt and the state, and forces cen_o=0.
  - ina_o and inb_o keep their values during hold.
  - hold is ignored in IDLE, PULSE and DONE. A PULSE always completes.
- Without the macro, there is no hold port and behaviour is exactly as above.

Test Plan:
- Reset then start, SEED=16'hACE1: ina_o over the first 6 run cycles is 1,0,0,0,0,1; lfsr values are ACE1, E270, 7138, 389C, 1C4E, 0E27.
- CEN_PERIOD=3: cen_o in RUN follows the pattern 1,0,0,1,0,0,... CEN_PERIOD=1 gives cen_o constantly 1.
- RST_INTERVAL=4, RUN_LENGTH=10:
  - rst_o pulses for one cycle after cycle_cnt reaches 4 and after it reaches 8; the lfsr is frozen during each pulse.
  - done rises when cycle_cnt=10, with no pulse at 10.
  - Expected: busy high for 12 cycles total, then done=1.
- RUN_LENGTH=8, RST_INTERVAL=4: count 8 goes to DONE with no pulse, confirming DONE priority. Then start in DONE restarts the sequence with ina_o = SEED[0] = 1 on the first cycle.
- rst asserted during RUN at cycle_cnt=5: next cycle shows IDLE with all outputs 0 and cycle_cnt=0. A start pulse during RUN produces no change.
- FFPACK_STIM_HOLD_EN: hold=1 for 3 cycles at cycle_cnt=2 leaves cycle_cnt at 2 and cen_o=0 throughout. Resuming continues the lfsr sequence with no skipped value.

Source files
------------

// File: rtl/ffpack_stim_gen.sv
// LFSR-driven stimulus source for the FF-packing test top: serial data, CE and periodic clears.
// Optional FFPACK_STIM_HOLD_EN adds a hold input that freezes a running sequence.
module ffpack_stim_gen #(
  parameter int unsigned            LFSR_WIDTH   = 16,
  parameter logic [LFSR_WIDTH-1:0]  SEED         = 16'hACE1,
  parameter int unsigned            CEN_PERIOD   = 3,
  parameter int unsigned            RST_INTERVAL = 64,
  parameter int unsigned            RUN_LENGTH   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef FFPACK_STIM_HOLD_EN
  input  logic        hold,
`endif
  output logic        busy,
  output logic        done,
  output logic        cen_o,
  output logic        rst_o,
  output logic        ina_o,
  output logic        inb_o,
  output logic [15:0] cycle_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned CEN_W = 8;
  localparam logic [LFSR_WIDTH-1:0] FB_MASK  = LFSR_WIDTH'(16'hB400);
  localparam logic [LFSR_WIDTH-1:0] SEED_EFF = (SEED == '0) ? LFSR_WIDTH'(1) : SEED;
  localparam logic [CNT_W-1:0]      RUN_LEN  = CNT_W'(RUN_LENGTH);
  localparam logic [CNT_W-1:0]      RST_INT  = CNT_W'(RST_INTERVAL);
  localparam logic [CEN_W-1:0]      CEN_LAST = CEN_W'(CEN_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PULSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]      cnt_d, cnt_inc;
  logic [CEN_W-1:0]      cen_cnt_q, cen_cnt_d;
  logic                  busy_d, done_d, cen_d, rst_o_d, ina_d, inb_d;
  logic                  hold_req, hold_run;

`ifdef FFPACK_STIM_HOLD_EN
  assign hold_req = hold;
`else
  assign hold_req = 1'b0;
`endif

  // State, sequence registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= '0;
      cycle_cnt <= '0;
      cen_cnt_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cen_o     <= 1'b0;
      rst_o     <= 1'b0;
      ina_o     <= 1'b0;
      inb_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cycle_cnt <= cnt_d;
      cen_cnt_q <= cen_cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      cen_o     <= cen_d;
      rst_o     <= rst_o_d;
      ina_o     <= ina_d;
      inb_o     <= inb_d;
    end
  end

  // Next state; outputs are derived from the next values so they line up with the visible state
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cycle_cnt;
    cen_cnt_d = cen_cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    cen_d     = 1'b0;
    rst_o_d   = 1'b0;
    ina_d     = 1'b0;
    inb_d     = 1'b0;
    hold_run  = 1'b0;
    cnt_inc   = cycle_cnt + CNT_W'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          lfsr_d    = SEED_EFF;
          cnt_d     = '0;
          cen_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (hold_req) begin
          hold_run = 1'b1;
        end else begin
          lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? FB_MASK : '0);
          cnt_d     = cnt_inc;
          cen_cnt_d = (cen_cnt_q >= CEN_LAST) ? '0 : cen_cnt_q + CEN_W'(1);
          if (cnt_inc == RUN_LEN) begin
            state_d = S_DONE;
          end else if ((cnt_inc % RST_INT) == '0) begin
            state_d = S_PULSE;
          end
        end
      end
      S_PULSE: state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_RUN: begin
        busy_d = 1'b1;
        if (hold_run) begin
          ina_d = ina_o;
          inb_d = inb_o;
        end else begin
          cen_d = (cen_cnt_d == '0);
          ina_d = lfsr_d[0];
          inb_d = lfsr_d[1];
        end
      end
      S_PULSE: begin
        busy_d  = 1'b1;
        rst_o_d = 1'b1;
        cen_d   = 1'b1;
        ina_d   = ina_o;
        inb_d   = inb_o;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ffpack_stim_gen.sv
// Scoreboard bench for ffpack_stim_gen: a sequence-level model queues per-cycle expected outputs.
module tb_ffpack_stim_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int CP = 3;
  localparam int RI = 4;
  localparam int RL = 12;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cen;
    logic        rsto;
    logic        ina;
    logic        inb;
    logic [15:0] cnt;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, cen_o, rst_o, ina_o, inb_o;
  logic [15:0] cycle_cnt;

  int total = 0;
  int bad = 0;

  frame_t sb[$];
  frame_t plan[$];
  int     mode = 0;  // 0 idle, 1 sequence active, 2 finished

  ffpack_stim_gen #(
    .LFSR_WIDTH(16), .SEED(SEED), .CEN_PERIOD(CP), .RST_INTERVAL(RI), .RUN_LENGTH(RL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .cen_o(cen_o), .rst_o(rst_o),
    .ina_o(ina_o), .inb_o(inb_o), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Whole sequence as seen on the outputs: run cycles with clear pulses after each interval
  task automatic build_plan();
    logic [15:0] lf;
    lf = (SEED == 16'h0) ? 16'h0001 : SEED;
    plan.delete();
    for (int k = 0; k < RL; k++) begin
      plan.push_back('{1'b1, 1'b0, (k % CP) == 0, 1'b0, lf[0], lf[1], 16'(k)});
      if (((k + 1) % RI) == 0 && (k + 1) != RL)
        plan.push_back('{1'b1, 1'b0, 1'b1, 1'b1, lf[0], lf[1], 16'(k + 1)});
      lf = lfsr_next(lf);
    end
  endtask

  task automatic model_step(input logic s, input logic r);
    frame_t f;
    frame_t fdone;
    fdone = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'(RL)};
    if (r) begin
      plan.delete();
      mode = 0;
      f = '0;
    end else if (plan.size() > 0) begin
      f = plan.pop_front();
    end else if (mode == 1) begin
      mode = 2;
      f = fdone;
    end else if (s) begin
      build_plan();
      mode = 1;
      f = plan.pop_front();
    end else if (mode == 2) begin
      f = fdone;
    end else begin
      f = '0;
    end
    sb.push_back(f);
  endtask

  task automatic tick(input logic s, input logic r);
    start = s;
    rst   = r;
    @(posedge clk);
    #1;
    model_step(s, r);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every cycle is an output beat; compare against the oldest queued expectation
  always @(negedge clk) begin
    frame_t e;
    frame_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{busy, done, cen_o, rst_o, ina_o, inb_o, cycle_cnt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL frame t=%0t got busy=%b done=%b cen=%b rst_o=%b ina=%b inb=%b cnt=%0d expected busy=%b done=%b cen=%b rst_o=%b ina=%b inb=%b cnt=%0d",
                 $time, a.busy, a.done, a.cen, a.rsto, a.ina, a.inb, a.cnt,
                 e.busy, e.done, e.cen, e.rsto, e.ina, e.inb, e.cnt);
      end
      total++;
      if (busy === 1'b1 && done === 1'b1) begin
        bad++;
        $display("FAIL busy_done_exclusive: got both high expected at most one");
      end
    end
  end

  initial begin
    logic [5:0] ina_ref;
    int run_i;
    int busy_n;
    int pulse_n;
    bit seen_done;
    bit reached;
    ina_ref = 6'b100001;  // run cycles 0..5, bit i = cycle i

    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);  // start under reset is overridden
    check("reset_cnt", int'(cycle_cnt), 0);

    // Full sequence: first data bits, pulse count, busy length, ignored start
    tick(1'b1, 1'b0);
    run_i = 0; busy_n = 0; pulse_n = 0; seen_done = 0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (done) begin
        seen_done = 1;
      end else begin
        if (busy) busy_n++;
        if (rst_o) pulse_n++;
        if (busy && !rst_o) begin
          if (run_i < 6) check($sformatf("ina_run%0d", run_i), int'(ina_o), int'(ina_ref[run_i]));
          run_i++;
        end
        tick(i == 3, 1'b0);
      end
    end
    check("done_reached", int'(seen_done), 1);
    check("busy_cycles", busy_n, RL + (RL - 1) / RI);
    check("pulse_count", pulse_n, (RL - 1) / RI);
    check("done_cnt", int'(cycle_cnt), RL);

    // Idle in DONE, then restart
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("restart_ina", int'(ina_o), int'(SEED[0]));
    check("restart_cnt", int'(cycle_cnt), 0);
    check("restart_busy", int'(busy), 1);

    // Abort mid-run at count 5
    reached = 0;
    for (int i = 0; i < 12 && !reached; i++) begin
      if (cycle_cnt == 16'd5 && !rst_o) reached = 1;
      else tick(1'b0, 1'b0);
    end
    check("reach_cnt5", int'(reached), 1);
    tick(1'b0, 1'b1);
    check("abort_cnt", int'(cycle_cnt), 0);
    check("abort_busy", int'(busy), 0);
    tick(1'b0, 1'b0);

    // Randomized start/reset traffic
    for (int i = 0; i < 3000; i++)
      tick(($urandom % 4) == 0, ($urandom % 50) == 0);

    tick(1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
